radar_roi_streamer: RTL
=======================

# radar_roi_streamer

Parametrised region-of-interest pixel streamer for the radar datapath. It reads a rectangular window `[row_idx1..row_idx2] x [col_idx1..col_idx2]` from an external frame buffer and streams the pixels out with start/end framing. It supports multiple channels in one transfer, selected by a channel mask, and applies downstream valid/ready backpressure. It sits between the frame-buffer RAM and the downstream detection stage and generalises the single-channel, no-backpressure window reader.

## Interface
- `ROWS`, 64, frame rows; `ROW_W = $clog2(ROWS)`
- `COLS`, 64, frame columns; `COL_W = $clog2(COLS)`
- `CHANNELS`, 4, channel count; `CH_W = $clog2(CHANNELS)`
- `DATA_W`, 16, pixel width
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock, synchronous, active-low
- `start`  in  1  single-cycle request; window inputs sampled with it
- `row_idx1`, `row_idx2`  in  ROW_W  first/last row, inclusive
- `col_idx1`, `col_idx2`  in  COL_W  first/last column, inclusive
- `channel_mask`  in  CHANNELS  channels to stream, ascending order
- `busy`  out  1  transfer in progress
- `err`  out  1  one-cycle pulse: request rejected
- `mem_rd_en`  out  1  frame-buffer read strobe
- `mem_addr`  out  CH_W+ROW_W+COL_W  `{ch,row,col}`
- `mem_rdata`  in  DATA_W  read data, valid exactly 1 cycle after `mem_rd_en`
- `pixel_out`  out  DATA_W  pixel
- `chan_out`  out  CH_W  channel tag of `pixel_out`
- `pixel_valid`  out  1  output valid
- `pixel_ready`  in  1  downstream accept
- `data_start`  out  1  first pixel of transfer, qualified by `pixel_valid`
- `data_end`  out  1  last pixel of transfer, qualified by `pixel_valid`

## Operation
- Scan order: channel (ascending set bits of mask), then row r1..r2, then column c1..c2.
- Pixel count = popcount(mask)·(r2−r1+1)·(c2−c1+1).
- Request validity:
  - Reject if r1>r2, c1>c2, r2≥ROWS, c2≥COLS or mask==0.
  - On reject: `err`=1 for exactly the cycle after `start`; no reads; stay IDLE.
- FSM `IDLE`→`ISSUE`→`DRAIN`→`IDLE`:
  - IDLE: a valid `start` latches the window and mask, then enters ISSUE.
  - ISSUE: one read per cycle while credit allows. After the last address is issued, enter DRAIN.
  - DRAIN: wait for the last pixel handshake, then return to IDLE.
- `busy` = state≠IDLE.
- `start` while busy is ignored (no err).
- Credit rule: issue when `fifo_count + outstanding − pop < 2`, where pop = `pixel_valid & pixel_ready` this cycle. This sustains 1 pixel/cycle with ready held high. No read data is ever dropped.
- `data_start`/`data_end` travel as FIFO tag bits with the pixel. A 1-pixel transfer asserts both on the same pixel.
- While `pixel_valid & !pixel_ready`, `pixel_out`, `chan_out`, `data_start` and `data_end` hold stable.
- Reset, including mid-transfer:
  - Clears FSM, counters, FIFO and outstanding flag.
  - Late `mem_rdata` is ignored.
  - Reset values: all outputs 0, `mem_addr` 0.

## Timing
- `start` high in cycle 0 → `busy`=1 and first `mem_rd_en` in cycle 1 → data in cycle 2 → `pixel_valid` in cycle 3.
- Start-to-first-pixel latency is 3 cycles.
- Last handshake in cycle N → `busy`=0 in cycle N+1. A new `start` is accepted in cycle N+1.
- Reject: `err`=1 in cycle 1; `busy` stays 0.

## Structure
- Package `radar_roi_pkg`: FSM state enum (`IDLE`, `ISSUE`, `DRAIN`) and width helper localparams.
- Sub-module `radar_roi_fifo`: 2-entry FIFO, `DATA_W+CH_W+2` bits wide, with `count` output.
- Top holds the FSM, the row/col/channel counters, the next-set-bit channel search and the credit logic.

## Test plan
Default for scenarios 1–5: ROWS=COLS=8, CHANNELS=4; memory model `mem[ch][r][c] = ch*256 + r*16 + c`.
1. r1=2, c1=3, r2=3, c2=4, mask=0001, ready=1 → pixels 0x023, 0x024, 0x033, 0x034 on consecutive cycles. First `pixel_valid` is 3 cycles after `start`; `data_start` on 0x023, `data_end` on 0x034.
2. r=c=5 single pixel, mask=1010 → 0x155 (chan 1, `data_start`), then 0x355 (chan 3, `data_end`).
3. Repeat scenario 1 with a full 8×8 window, mask=1111 and random 50% `pixel_ready` → 256 pixels in exact scan order, no drop or duplicate, outputs stable during stalls.
4. Invalid requests (r1=4/r2=3; mask=0; c2 out of range for a COLS=6 build) → `err` one-cycle pulse, `busy`=0, no `mem_rd_en`.
5. `start` during busy → ignored. Then `rst_n` low one cycle after 5 pixels → all outputs 0 next cycle; a fresh request then completes correctly.
6. Default parameters (64×64, 4 channels), full frame, mask=1111, ready=1 → 16384 handshakes in 16384 consecutive cycles.

Source files
------------

// File: rtl/radar_roi_pkg.sv
// Shared types and width helpers for the radar ROI streamer slice.
package radar_roi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Each FIFO entry carries the start/end framing flags next to the pixel.
  localparam int unsigned TAG_W = 2;

  function automatic int unsigned entry_w(input int unsigned data_w, input int unsigned ch_w);
    return data_w + ch_w + TAG_W;
  endfunction

endpackage

// File: rtl/radar_roi_if.sv
// Pixel output stream: valid/ready handshake with channel tag and framing.
interface radar_roi_if #(
  parameter int DATA_W = 16,
  parameter int CH_W   = 2
);
  logic [DATA_W-1:0] pixel_out;
  logic [CH_W-1:0]   chan_out;
  logic              pixel_valid;
  logic              pixel_ready;
  logic              data_start;
  logic              data_end;

  modport master (
    output pixel_out, chan_out, pixel_valid, data_start, data_end,
    input  pixel_ready
  );

  modport slave (
    input  pixel_out, chan_out, pixel_valid, data_start, data_end,
    output pixel_ready
  );
endinterface

// File: rtl/radar_roi_fifo.sv
// Two-entry FIFO holding read data plus tags between the frame buffer and the stream.
module radar_roi_fifo #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/radar_roi_streamer.sv
// Streams a rectangular window of one or more frame-buffer channels with
// start/end framing and downstream backpressure.
module radar_roi_streamer
  import radar_roi_pkg::*;
#(
  parameter int ROWS     = 64,
  parameter int COLS     = 64,
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 16,
  localparam int ROW_W   = $clog2(ROWS),
  localparam int COL_W   = $clog2(COLS),
  localparam int CH_W    = $clog2(CHANNELS),
  localparam int ADDR_W  = CH_W + ROW_W + COL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ROW_W-1:0]    row_idx1,
  input  logic [ROW_W-1:0]    row_idx2,
  input  logic [COL_W-1:0]    col_idx1,
  input  logic [COL_W-1:0]    col_idx2,
  input  logic [CHANNELS-1:0] channel_mask,
  output logic                busy,
  output logic                err,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  radar_roi_if.master         pix
);
  localparam int ENTRY_W = entry_w(DATA_W, CH_W);

  state_e              state;
  logic [ROW_W-1:0]    r1_q, r2_q, row_q;
  logic [COL_W-1:0]    c1_q, c2_q, col_q;
  logic [CHANNELS-1:0] mask_q;
  logic [CH_W-1:0]     ch_q, rd_ch;
  logic                first_q, outstanding, rd_first, rd_last, err_q;

  logic                req_ok, issue, pop, last_addr, has_next;
  logic [CH_W-1:0]     first_set, next_set;
  logic [1:0]          fifo_count;
  logic [ENTRY_W-1:0]  fifo_in, fifo_head;

  assign req_ok = (row_idx1 <= row_idx2) && (col_idx1 <= col_idx2) &&
                  (int'(row_idx2) < ROWS) && (int'(col_idx2) < COLS) &&
                  (|channel_mask);

  // Descending scan so the final hit is the lowest qualifying channel.
  always_comb begin
    first_set = '0;
    next_set  = '0;
    has_next  = 1'b0;
    for (int unsigned i = CHANNELS; i > 0; i--) begin
      if (channel_mask[i-1]) first_set = CH_W'(i-1);
      if (mask_q[i-1] && (CH_W'(i-1) > ch_q)) begin
        next_set = CH_W'(i-1);
        has_next = 1'b1;
      end
    end
  end

  assign pop       = pix.pixel_valid & pix.pixel_ready;
  // Credit: FIFO occupancy plus in-flight read, net of this cycle's pop, must leave room.
  assign issue     = (state == ISSUE) &&
                     (({1'b0, fifo_count} + {2'b0, outstanding}) < (3'd2 + {2'b0, pop}));
  assign last_addr = !has_next && (row_q == r2_q) && (col_q == c2_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      r1_q        <= '0;
      r2_q        <= '0;
      row_q       <= '0;
      c1_q        <= '0;
      c2_q        <= '0;
      col_q       <= '0;
      mask_q      <= '0;
      ch_q        <= '0;
      first_q     <= 1'b0;
      outstanding <= 1'b0;
      rd_ch       <= '0;
      rd_first    <= 1'b0;
      rd_last     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q       <= (state == IDLE) && start && !req_ok;
      outstanding <= issue;
      rd_ch       <= ch_q;
      rd_first    <= first_q;
      rd_last     <= last_addr;
      case (state)
        IDLE: begin
          if (start && req_ok) begin
            r1_q    <= row_idx1;
            r2_q    <= row_idx2;
            c1_q    <= col_idx1;
            c2_q    <= col_idx2;
            mask_q  <= channel_mask;
            row_q   <= row_idx1;
            col_q   <= col_idx1;
            ch_q    <= first_set;
            first_q <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            first_q <= 1'b0;
            if (col_q != c2_q) begin
              col_q <= col_q + COL_W'(1);
            end else begin
              col_q <= c1_q;
              if (row_q != r2_q) begin
                row_q <= row_q + ROW_W'(1);
              end else begin
                row_q <= r1_q;
                ch_q  <= next_set;
              end
            end
            if (last_addr) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && pix.data_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_in = {rd_first, rd_last, rd_ch, mem_rdata};

  radar_roi_fifo #(.W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (outstanding),
    .wdata (fifo_in),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  assign busy            = (state != IDLE);
  assign err             = err_q;
  assign mem_rd_en       = issue;
  assign mem_addr        = {ch_q, row_q, col_q};
  assign pix.pixel_valid = (fifo_count != 2'd0);
  assign pix.pixel_out   = fifo_head[DATA_W-1:0];
  assign pix.chan_out    = fifo_head[DATA_W +: CH_W];
  assign pix.data_end    = fifo_head[DATA_W+CH_W];
  assign pix.data_start  = fifo_head[DATA_W+CH_W+1];
endmodule
